// File: rtl/floor_pkg.sv
// Shared definitions for the elevator floor-request front end: floor codes,
// controller states, pending-bit indices and floor selection helpers.
package floor_pkg;

  localparam logic [3:0] FLOOR_G = 4'd0;
  localparam logic [3:0] FLOOR_1 = 4'd1;
  localparam logic [3:0] FLOOR_2 = 4'd2;

  localparam int PEND_G = 0;
  localparam int PEND_1 = 1;
  localparam int PEND_2 = 2;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    WAIT_ARRIVE = 2'd2,
    EMERG       = 2'd3
  } ctrl_state_e;

  function automatic logic [2:0] floor_onehot(input logic [1:0] floor);
    case (floor)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Nearest pending floor to cur; the cur = 1 tie between 0 and 2 goes low.
  function automatic logic [1:0] nearest_floor(input logic [1:0] cur,
                                               input logic [2:0] pend);
    case (cur)
      2'd0:    return pend[PEND_G] ? 2'd0 : (pend[PEND_1] ? 2'd1 : 2'd2);
      2'd1:    return pend[PEND_1] ? 2'd1 : (pend[PEND_G] ? 2'd0 : 2'd2);
      default: return pend[PEND_2] ? 2'd2 : (pend[PEND_1] ? 2'd1 : 2'd0);
    endcase
  endfunction

endpackage

// File: rtl/floor_request_ctrl_debounce.sv
// Two-flop synchronizer, counting debouncer and rising-edge press pulse for
// one raw push button.
module btn_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int DB_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            level;
  logic [DB_W-1:0] cnt;

  // The level flips on the DB_CYCLES-th consecutive disagreeing sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/floor_request_ctrl.sv
// Request front end for the three-floor elevator FSM: debounces call buttons,
// latches pending calls and issues one floor request at a time.
module floor_request_ctrl #(
  parameter int DB_CYCLES    = 4,
  parameter int DB_W         = 16,
  parameter int RETRY_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_g,
  input  logic       btn_f,
  input  logic       btn_s,
  input  logic       btn_emerg,
  input  logic [3:0] cur_floor,
  input  logic       emerg_ack,
  output logic       g_f,
  output logic       f_f,
  output logic       s_f,
  output logic       emerg_req,
  output logic [2:0] pending,
  output logic       busy
);

  import floor_pkg::*;

  localparam int RW = $clog2(RETRY_CYCLES + 1);
  localparam logic [RW-1:0] RETRY_LOAD = RW'(RETRY_CYCLES);

  ctrl_state_e   state, state_next;
  logic [1:0]    target, target_next;
  logic [RW-1:0] retry_cnt, retry_next;
  logic [2:0]    pending_next;
  logic [2:0]    req_next;
  logic [2:0]    set_mask;
  logic [2:0]    clr_mask;
  logic [3:0]    raw_btn;
  logic [3:0]    press;
  logic          cur_valid;
  logic          arrived;
  logic          emerg_evt;

  assign raw_btn = {btn_emerg, btn_s, btn_f, btn_g};

  for (genvar i = 0; i < 4; i++) begin : g_db
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .DB_W     (DB_W)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_btn[i]),
      .press(press[i])
    );
  end

  assign cur_valid = (cur_floor <= FLOOR_2);
  assign arrived   = (cur_floor == {2'b00, target});
  assign emerg_evt = press[3] | emerg_ack;
  assign busy      = (state == ISSUE) || (state == WAIT_ARRIVE);

  // Emergency overrides everything after the normal next-state decision, and
  // an arrival clear beats a same-cycle press on the same pending bit.
  always_comb begin
    state_next  = state;
    target_next = target;
    retry_next  = retry_cnt;
    clr_mask    = 3'b000;
    set_mask    = press[2:0];
    if (state == IDLE && cur_valid) begin
      set_mask = press[2:0] & ~floor_onehot(cur_floor[1:0]);
    end
    case (state)
      IDLE: begin
        if (pending != 3'b000 && cur_valid) begin
          target_next = nearest_floor(cur_floor[1:0], pending);
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        retry_next = RETRY_LOAD;
        state_next = WAIT_ARRIVE;
      end
      WAIT_ARRIVE: begin
        if (arrived) begin
          clr_mask   = floor_onehot(target);
          state_next = IDLE;
        end else if (retry_cnt <= RW'(1)) begin
          state_next = ISSUE;
        end else begin
          retry_next = retry_cnt - RW'(1);
        end
      end
      EMERG: state_next = EMERG;
      default: state_next = IDLE;
    endcase
    if (emerg_evt) begin
      state_next = EMERG;
    end
    if (emerg_evt || state == EMERG) begin
      pending_next = 3'b000;
    end else begin
      pending_next = (pending | set_mask) & ~clr_mask;
    end
    req_next = (state_next == ISSUE) ? floor_onehot(target_next) : 3'b000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      target    <= 2'd0;
      retry_cnt <= '0;
      pending   <= 3'b000;
      g_f       <= 1'b0;
      f_f       <= 1'b0;
      s_f       <= 1'b0;
      emerg_req <= 1'b0;
    end else begin
      state     <= state_next;
      target    <= target_next;
      retry_cnt <= retry_next;
      pending   <= pending_next;
      g_f       <= req_next[PEND_G];
      f_f       <= req_next[PEND_1];
      s_f       <= req_next[PEND_2];
      emerg_req <= press[3] && (state != EMERG);
    end
  end

endmodule

// File: tb/tb_floor_request_ctrl.sv
// Self-checking bench for floor_request_ctrl: a rule-level model checked every
// cycle plus directed scenarios with hand-computed expectations.
module tb_floor_request_ctrl;

  localparam int DB    = 4;
  localparam int RETRY = 8;

  localparam int M_IDLE  = 0;
  localparam int M_ISSUE = 1;
  localparam int M_WAIT  = 2;
  localparam int M_EMERG = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_g = 1'b0, btn_f = 1'b0, btn_s = 1'b0, btn_emerg = 1'b0;
  logic [3:0] cur_floor = 4'd0;
  logic       emerg_ack = 1'b0;
  logic       g_f, f_f, s_f, emerg_req, busy;
  logic [2:0] pending;

  int tests = 0;
  int fails = 0;

  floor_request_ctrl #(
    .DB_CYCLES   (DB),
    .DB_W        (16),
    .RETRY_CYCLES(RETRY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_g    (btn_g),
    .btn_f    (btn_f),
    .btn_s    (btn_s),
    .btn_emerg(btn_emerg),
    .cur_floor(cur_floor),
    .emerg_ack(emerg_ack),
    .g_f      (g_f),
    .f_f      (f_f),
    .s_f      (s_f),
    .emerg_req(emerg_req),
    .pending  (pending),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  bit [15:0] hist [4];
  bit        m_level [4];
  bit [3:0]  m_press;
  bit [2:0]  m_pend;
  bit [2:0]  m_req;
  bit        m_ereq;
  int        m_mode;
  int        m_target;
  int        cyc;
  int        last_issue;

  function automatic int pick_nearest(input int cur, input bit [2:0] pend);
    for (int d = 0; d <= 2; d++)
      for (int f = 0; f <= 2; f++)
        if (pend[f] && ((f > cur) ? f - cur : cur - f) == d) return f;
    return 0;
  endfunction

  task reset_model();
    for (int b = 0; b < 4; b++) begin
      hist[b]    = '0;
      m_level[b] = 1'b0;
    end
    m_press = '0; m_pend = '0; m_req = '0; m_ereq = 1'b0;
    m_mode = M_IDLE; m_target = 0; cyc = 0; last_issue = 0;
  endtask

  // Press pulses act one edge after the debouncer produces them.
  task step_model();
    bit [3:0] raw;
    bit [3:0] np;
    bit [2:0] setm, clrm, old_pend;
    int       old_mode, cur;
    bit       emerg, all_diff;
    raw = {btn_emerg, btn_s, btn_f, btn_g};
    cur = int'(cur_floor);
    cyc++;
    old_mode = m_mode;
    old_pend = m_pend;
    emerg = m_press[3] || emerg_ack;
    m_ereq = 1'b0;
    m_req = '0;
    if (old_mode == M_EMERG || emerg) begin
      m_ereq = m_press[3] && (old_mode != M_EMERG);
      m_mode = M_EMERG;
      m_pend = '0;
    end else begin
      setm = m_press[2:0];
      if (old_mode == M_IDLE && cur <= 2) setm[cur] = 1'b0;
      clrm = '0;
      case (old_mode)
        M_IDLE: if (old_pend != 0 && cur <= 2) begin
          m_target = pick_nearest(cur, old_pend);
          m_mode = M_ISSUE;
          last_issue = cyc;
        end
        M_ISSUE: m_mode = M_WAIT;
        M_WAIT: if (cur == m_target) begin
          clrm[m_target] = 1'b1;
          m_mode = M_IDLE;
        end else if (cyc - last_issue == RETRY + 1) begin
          m_mode = M_ISSUE;
          last_issue = cyc;
        end
        default: m_mode = M_IDLE;
      endcase
      m_pend = (old_pend | setm) & ~clrm;
      if (m_mode == M_ISSUE) m_req[m_target] = 1'b1;
    end
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      for (int j = 1; j <= DB; j++)
        if (hist[b][j] == m_level[b]) all_diff = 1'b0;
      np[b] = 1'b0;
      if (all_diff) begin
        m_level[b] = ~m_level[b];
        np[b] = m_level[b];
      end
      hist[b] = {hist[b][14:0], raw[b]};
    end
    m_press = np;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) reset_model();
    else step_model();
  end

  always begin
    bit m_busy;
    @(negedge clk);
    #1;
    m_busy = (m_mode == M_ISSUE) || (m_mode == M_WAIT);
    tests++;
    if ({g_f, f_f, s_f, emerg_req, busy, pending} !==
        {m_req[0], m_req[1], m_req[2], m_ereq, m_busy, m_pend}) begin
      fails++;
      $display("[TB] FAIL model_cmp t=%0t dut gfs=%b%b%b ereq=%b busy=%b pend=%b required gfs=%b%b%b ereq=%b busy=%b pend=%b",
               $time, g_f, f_f, s_f, emerg_req, busy, pending,
               m_req[0], m_req[1], m_req[2], m_ereq, m_busy, m_pend);
    end
  end

  task check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s t=%0t got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  task apply_stimulus(input logic g, input logic f, input logic s, input logic e,
                      input logic [3:0] cur, input logic ack);
    btn_g = g; btn_f = f; btn_s = s; btn_emerg = e;
    cur_floor = cur; emerg_ack = ack;
  endtask

  task tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int nf, nrise, arr;
    bit prev_p1;

    apply_stimulus(0, 0, 0, 0, 4'd0, 0);
    tick(3);
    check_output("rst_pending", 8'(pending), 8'h0);
    check_output("rst_req", 8'({g_f, f_f, s_f}), 8'h0);
    check_output("rst_busy", 8'(busy), 8'h0);
    check_output("rst_ereq", 8'(emerg_req), 8'h0);
    reset = 1'b0;
    tick(2);

    $display("[TB] btn_s from ground");
    apply_stimulus(0, 0, 1, 0, 4'd0, 0);
    tick(6);  check_output("s_pend_pre", 8'(pending), 8'h0);
    tick(1);  check_output("s_pend_set", 8'(pending), 8'h4);
              check_output("s_req_early", 8'(s_f), 8'h0);
    tick(1);  check_output("s_issue", 8'({g_f, f_f, s_f}), 8'h1);
              check_output("s_busy", 8'(busy), 8'h1);
    tick(1);  check_output("s_one_cycle", 8'(s_f), 8'h0);
              check_output("s_wait_busy", 8'(busy), 8'h1);
    tick(1);  apply_stimulus(0, 0, 0, 0, 4'd2, 0);
    tick(1);  check_output("s_arrive_pend", 8'(pending), 8'h0);
              check_output("s_arrive_busy", 8'(busy), 8'h0);
    tick(10);

    $display("[TB] bouncy btn_f");
    nf = 0; nrise = 0; arr = -100; prev_p1 = pending[1];
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(0, ((i / 2) % 2) == 0, 0, 0, 4'd2, 0);
      tick(1);
      if (f_f) nf++;
      if (pending[1] && !prev_p1) nrise++;
      prev_p1 = pending[1];
    end
    btn_f = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (f_f) begin nf++; if (arr < 0) arr = c; end
      if (pending[1] && !prev_p1) nrise++;
      prev_p1 = pending[1];
      if (c == arr + 2) cur_floor = 4'd1;
    end
    btn_f = 1'b0;
    tick(10);
    check_output("bounce_f_pulses", 8'(nf), 8'd1);
    check_output("bounce_pend_sets", 8'(nrise), 8'd1);
    check_output("bounce_pend_end", 8'(pending), 8'h0);

    $display("[TB] tie at first floor");
    apply_stimulus(0, 0, 0, 0, 4'd1, 0);
    tick(2);
    apply_stimulus(1, 0, 1, 0, 4'd1, 0);
    tick(7);  check_output("tie_pend", 8'(pending), 8'h5);
    tick(1);  check_output("tie_g_first", 8'({g_f, f_f, s_f}), 8'h4);
    tick(2);  apply_stimulus(0, 0, 0, 0, 4'd0, 0);
    tick(1);  check_output("tie_pend_after_g", 8'(pending), 8'h4);
              check_output("tie_idle", 8'(busy), 8'h0);
    tick(1);  check_output("tie_s_next", 8'({g_f, f_f, s_f}), 8'h1);
    tick(2);  cur_floor = 4'd2;
    tick(1);  check_output("tie_pend_done", 8'(pending), 8'h0);
    tick(8);

    $display("[TB] retry with cur_floor stuck at ground");
    apply_stimulus(0, 0, 0, 0, 4'd0, 0);
    tick(2);
    btn_f = 1'b1;
    tick(6);
    btn_f = 1'b0;
    for (int n = 7; n <= 26; n++) begin
      tick(1);
      if (n >= 8) check_output($sformatf("retry_f_%0d", n), 8'(f_f), 8'(((n - 8) % 9) == 0));
    end
    cur_floor = 4'd1;
    tick(1);  check_output("retry_wait_pend", 8'(pending), 8'h2);
    tick(1);  check_output("retry_done_pend", 8'(pending), 8'h0);
              check_output("retry_done_busy", 8'(busy), 8'h0);
    tick(5);

    $display("[TB] reset during WAIT_ARRIVE");
    apply_stimulus(0, 0, 1, 0, 4'd0, 0);
    tick(6);  btn_s = 1'b0;
    tick(3);  check_output("abort_busy_pre", 8'(busy), 8'h1);
    tick(1);  reset = 1'b1;
    #1;       check_output("abort_pend", 8'(pending), 8'h0);
              check_output("abort_busy", 8'(busy), 8'h0);
              check_output("abort_req", 8'({g_f, f_f, s_f}), 8'h0);
    tick(2);  reset = 1'b0;
    tick(5);  check_output("abort_stays_idle", 8'(busy), 8'h0);

    $display("[TB] emergency press during WAIT_ARRIVE");
    apply_stimulus(0, 1, 1, 0, 4'd0, 0);
    tick(5);  btn_emerg = 1'b1;
    tick(1);  btn_f = 1'b0; btn_s = 1'b0;
    tick(2);  check_output("em_f_issue", 8'({g_f, f_f, s_f}), 8'h2);
    tick(3);  check_output("em_pend_pre", 8'(pending), 8'h6);
              check_output("em_busy_pre", 8'(busy), 8'h1);
              check_output("em_req_pre", 8'(emerg_req), 8'h0);
    tick(1);  check_output("em_req", 8'(emerg_req), 8'h1);
              check_output("em_pend_clr", 8'(pending), 8'h0);
              check_output("em_busy", 8'(busy), 8'h0);
    tick(1);  check_output("em_req_one", 8'(emerg_req), 8'h0);
              btn_emerg = 1'b0;
    btn_s = 1'b1;
    tick(8);  btn_s = 1'b0;
    tick(6);  check_output("em_press_ignored", 8'(pending), 8'h0);
    reset = 1'b1;
    tick(2);  reset = 1'b0;
    apply_stimulus(1, 0, 0, 0, 4'd2, 0);
    tick(6);  btn_g = 1'b0;
    tick(1);  check_output("em_exit_pend", 8'(pending), 8'h1);
    tick(3);  cur_floor = 4'd0;
    tick(3);

    $display("[TB] emerg_ack in IDLE");
    emerg_ack = 1'b1;
    tick(1);  check_output("ack_no_req", 8'(emerg_req), 8'h0);
              emerg_ack = 1'b0;
    btn_f = 1'b1;
    tick(8);  btn_f = 1'b0;
    tick(4);  check_output("ack_press_ignored", 8'(pending), 8'h0);
    reset = 1'b1;
    tick(2);  reset = 1'b0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/floor_request_ctrl.md
Name: floor_request_ctrl

Overview:
Front-end request controller for the three-floor elevator FSM. Conditions raw call buttons and selects one pending floor at a time. It drives the FSM's one-hot floor-request inputs and emergency input, then watches the FSM's current-floor code to confirm arrival. This block is the requester; the elevator FSM is the responder.

Parameters:
DB_CYCLES, 4, consecutive stable samples required to accept a button level change (use 50000 for board).
DB_W, 16, debounce counter width.
RETRY_CYCLES, 8, cycles to wait for arrival before re-issuing the request.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
btn_g  in  1  raw ground-floor call button, asynchronous, active-high
btn_f  in  1  raw first-floor call button
btn_s  in  1  raw second-floor call button
btn_emerg  in  1  raw emergency button
cur_floor  in  4  FSM current-floor code: 0, 1 or 2
emerg_ack  in  1  FSM emergency-active flag
g_f  out  1  request: go to ground (one-hot with f_f, s_f)
f_f  out  1  request: go to first floor
s_f  out  1  request: go to second floor
emerg_req  out  1  emergency request to FSM
pending  out  3  latched calls; bit0 = ground, bit1 = first, bit2 = second
busy  out  1  high in ISSUE and WAIT_ARRIVE

Behaviour:
- Reset is asynchronous active-high, clock is clk. Reset drives all outputs to 0, pending to 3'b000, the state to IDLE, and the retry counter and debouncers to 0. Reset mid-operation aborts any request immediately.
- Button conditioning:
  - Each button has a 2-flop synchronizer.
  - A debounced level changes only after DB_CYCLES consecutive samples differ from the current debounced level. Any matching sample clears the counter.
  - A debounced rising edge produces a 1-cycle press pulse.
  - Latency from a clean raw edge to the press pulse is 2 + DB_CYCLES cycles.
- Pending latch:
  - A press sets the matching pending bit.
  - A press for cur_floor while in IDLE is ignored.
  - If a set and an arrival clear hit the same bit in the same cycle, the clear wins.
- Main FSM has four states: IDLE, ISSUE, WAIT_ARRIVE, EMERG.
- IDLE:
  - If pending is non-zero and cur_floor is in 0..2, select target = the nearest pending floor to cur_floor. On a tie (cur = 1, both 0 and 2 pending), choose the lower floor. Then go to ISSUE.
  - If cur_floor > 2, stay in IDLE and issue nothing.
- ISSUE:
  - Assert exactly one of g_f/f_f/s_f for 1 cycle.
  - Load the retry counter with RETRY_CYCLES, then go to WAIT_ARRIVE.
- WAIT_ARRIVE:
  - All request outputs are 0.
  - When cur_floor == target: clear pending[target] and go to IDLE.
  - Otherwise decrement the counter; at 0, go back to ISSUE.
  - Nominal FSM arrival is 2 cycles after the ISSUE cycle.
- Request outputs are registered and never overlap.
- Emergency:
  - A debounced emergency press, or emerg_ack = 1, in any state forces EMERG on the next edge.
  - Entry from a press asserts emerg_req for exactly 1 cycle. Entry from emerg_ack alone asserts nothing.
  - Entry clears pending and forces all request outputs to 0.
  - In EMERG: floor presses are ignored, pending stays 0, busy = 0. Only reset exits.
- Priority when events coincide: reset > emergency > arrival clear > new press > retry.

Decomposition:
- Shared package floor_pkg:
  - floor codes FLOOR_G = 4'd0, FLOOR_1 = 4'd1, FLOOR_2 = 4'd2;
  - controller state encodings IDLE/ISSUE/WAIT_ARRIVE/EMERG (2 bits);
  - pending bit indices.
- One sub-module: btn_debounce (synchronizer + counter + rising-edge pulse, parameters DB_CYCLES and DB_W). It is instantiated 4 times.

Test Plan:
- Reset with all buttons low -> all outputs 0, pending = 3'b000; an assert while mid-WAIT_ARRIVE aborts to IDLE with pending = 0.
- cur_floor = 0, btn_s held high 10 cycles (DB_CYCLES = 4) -> press pulse 6 cycles after the edge, pending = 3'b100, s_f high exactly 1 cycle, busy = 1. cur_floor driven to 2 two cycles later -> pending = 3'b000, busy = 0.
- Bouncy btn_f (toggle every 2 cycles for 12 cycles, then stable high) -> exactly one press, pending[1] set once, one f_f pulse.
- cur_floor = 1, btn_g and btn_s pressed the same cycle -> pending = 3'b101, g_f issued first. After cur_floor = 0: s_f issued, and pending goes to 3'b100 then 3'b000.
- Request f_f with cur_floor held at 0 -> f_f re-pulses every RETRY_CYCLES + 1 = 9 cycles until cur_floor = 1.
- btn_emerg pressed during WAIT_ARRIVE with pending = 3'b110 -> emerg_req high 1 cycle, pending = 0, later floor presses ignored. Separately, emerg_ack = 1 in IDLE -> EMERG with no emerg_req pulse. Reset -> IDLE in both cases.
